// File: rtl/queue_occ_pkg.sv
// rtl/queue_occ_pkg.sv - shared types, constants and width helper for the queue occupancy tracker
package queue_occ_pkg;

  // Default almost-empty threshold and the distance of almost-full below FIFO_SIZE
  localparam int DEF_AE_LVL    = 4;
  localparam int DEF_AF_MARGIN = 4;

  // Per-channel level flags, all derived from the registered count
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic last;
  } lvl_flags_t;

  // Count width: one extra bit so a completely full FIFO is representable
  function automatic int calc_cw(input int fifo_size);
    return $clog2(fifo_size) + 1;
  endfunction

endpackage

// File: rtl/queue_occ_ch.sv
// rtl/queue_occ_ch.sv - single-channel occupancy counter, level flags, peak and error tracking (QUEUE_OCC_ERR_EN enables ovf/udf)
module queue_occ_ch
  import queue_occ_pkg::*;
#(
  parameter int  FIFO_SIZE = 64,
  parameter int  AF_LVL    = FIFO_SIZE - DEF_AF_MARGIN,
  parameter int  AE_LVL    = DEF_AE_LVL,
  localparam int CW        = calc_cw(FIFO_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_en,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          ch_clr,
  input  logic          peak_clr,
  input  logic          err_clr,
  output logic [CW-1:0] count,
  output logic [CW-1:0] peak,
  output lvl_flags_t    flags,
  output logic          ovf,
  output logic          udf
);

  localparam logic [CW-1:0] MAX_CNT = CW'(FIFO_SIZE);
  localparam logic [CW-1:0] AF_CNT  = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_CNT  = CW'(AE_LVL);

  logic          wa;
  logic          ra;
  logic [CW-1:0] count_nxt;

  // Accept decisions; a read on empty is only legal when it consumes a same-cycle write
  always_comb begin
    wa = fifo_en & wr_en & (count < MAX_CNT);
    ra = rd_en & ((count != '0) | wa);
    if (ch_clr) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(wa) - CW'(ra);
    end
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  // High-water mark; a clear snaps it to the present occupancy rather than zero
  always_ff @(posedge clk) begin
    if (rst) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= count;
    end else if (count_nxt > peak) begin
      peak <= count_nxt;
    end
  end

  // Level flags from the registered count; last also anticipates a read leaving one entry
  always_comb begin
    flags.full         = (count == MAX_CNT);
    flags.empty        = (count == '0);
    flags.almost_full  = (count >= AF_CNT);
    flags.almost_empty = (count <= AE_CNT);
    flags.last         = (count == CW'(1)) | (rd_en & (count == CW'(2)));
  end

`ifdef QUEUE_OCC_ERR_EN
  logic ovf_set;
  logic udf_set;

  // A flush in the same cycle swallows the write, so it is not an overflow
  always_comb begin
    ovf_set = fifo_en & wr_en & ~wa & ~ch_clr;
    udf_set = rd_en & ~ra;
  end

  // Sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (udf_set) begin
        udf <= 1'b1;
      end else if (err_clr) begin
        udf <= 1'b0;
      end
    end
  end
`else
  // Error tracking absent: flags are constant zero and err_clr has no effect
  assign ovf = err_clr & 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: rtl/queue_occ_tracker.sv
// rtl/queue_occ_tracker.sv - NUM_CH independent queue occupancy trackers with packed outputs (QUEUE_OCC_ERR_EN enables ovf/udf)
module queue_occ_tracker
  import queue_occ_pkg::*;
#(
  parameter int  FIFO_SIZE = 64,
  parameter int  NUM_CH    = 4,
  parameter int  AF_LVL    = FIFO_SIZE - DEF_AF_MARGIN,
  parameter int  AE_LVL    = DEF_AE_LVL,
  localparam int CW        = calc_cw(FIFO_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    fifo_en,
  input  logic [NUM_CH-1:0]    wr_en,
  input  logic [NUM_CH-1:0]    rd_en,
  input  logic [NUM_CH-1:0]    ch_clr,
  input  logic [NUM_CH-1:0]    peak_clr,
  input  logic [NUM_CH-1:0]    err_clr,
  output logic [NUM_CH*CW-1:0] index,
  output logic [NUM_CH*CW-1:0] peak,
  output logic [NUM_CH-1:0]    last,
  output logic [NUM_CH-1:0]    full,
  output logic [NUM_CH-1:0]    empty,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH-1:0]    ovf,
  output logic [NUM_CH-1:0]    udf
);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    lvl_flags_t fl;

    queue_occ_ch #(
      .FIFO_SIZE (FIFO_SIZE),
      .AF_LVL    (AF_LVL),
      .AE_LVL    (AE_LVL)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .fifo_en  (fifo_en[n]),
      .wr_en    (wr_en[n]),
      .rd_en    (rd_en[n]),
      .ch_clr   (ch_clr[n]),
      .peak_clr (peak_clr[n]),
      .err_clr  (err_clr[n]),
      .count    (index[n*CW +: CW]),
      .peak     (peak[n*CW +: CW]),
      .flags    (fl),
      .ovf      (ovf[n]),
      .udf      (udf[n])
    );

    assign full[n]         = fl.full;
    assign empty[n]        = fl.empty;
    assign almost_full[n]  = fl.almost_full;
    assign almost_empty[n] = fl.almost_empty;
    assign last[n]         = fl.last;
  end

endmodule
